// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler: shadows PWM counter configurations and commits them atomically at a wrap or immediately with a restart.
// Optional build macro PWM_CFG_TIMEOUT_EN adds a PENDING watchdog and the sticky timeout output.
`default_nettype none

module pwm_cfg_scheduler #(
    parameter logic [15:0] RESET_PERIOD   = 16'hFFFF,
    parameter logic [7:0]  RESET_PRESCALE = 8'd0,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_period,
    input  logic [7:0]  cfg_prescale,
    input  logic        cfg_upnotdown,
    input  logic        cfg_en,
    input  logic        cfg_immediate,
    input  logic        cfg_abort,
    input  logic [15:0] count_val,
    output logic [15:0] period,
    output logic [7:0]  prescale,
    output logic        upnotdown,
    output logic        en,
    output logic        count_reset,
    output logic        busy,
`ifdef PWM_CFG_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic        applied
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RESTART = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] shadow_period;
    logic [7:0]  shadow_prescale;
    logic        shadow_upnotdown;
    logic        shadow_en;
    logic [15:0] prev_count;
    logic [15:0] term;
    logic        wrap;

`ifdef PWM_CFG_TIMEOUT_EN
    logic [23:0] wdog;
`else
    logic        unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    // A wrap is the counter leaving the active terminal value; a held terminal value is not a wrap.
    always_comb begin
        term = upnotdown ? period : 16'd0;
        wrap = (prev_count == term) && (count_val != prev_count);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            shadow_period    <= 16'd0;
            shadow_prescale  <= 8'd0;
            shadow_upnotdown <= 1'b0;
            shadow_en        <= 1'b0;
            prev_count       <= 16'd0;
            period           <= RESET_PERIOD;
            prescale         <= RESET_PRESCALE;
            upnotdown        <= 1'b1;
            en               <= 1'b0;
            count_reset      <= 1'b0;
            cfg_ready        <= 1'b1;
            busy             <= 1'b0;
            applied          <= 1'b0;
`ifdef PWM_CFG_TIMEOUT_EN
            timeout          <= 1'b0;
            wdog             <= 24'd0;
`endif
        end else begin
            prev_count <= count_val;
            applied    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        shadow_period    <= cfg_period;
                        shadow_prescale  <= cfg_prescale;
                        shadow_upnotdown <= cfg_upnotdown;
                        shadow_en        <= cfg_en;
                        cfg_ready        <= 1'b0;
                        busy             <= 1'b1;
`ifdef PWM_CFG_TIMEOUT_EN
                        timeout          <= 1'b0;
                        wdog             <= 24'd0;
`endif
                        // A stopped counter never wraps, so it is restarted straight away.
                        if (cfg_immediate || !en) begin
                            period      <= cfg_period;
                            prescale    <= cfg_prescale;
                            upnotdown   <= cfg_upnotdown;
                            en          <= cfg_en;
                            count_reset <= 1'b1;
                            state       <= RESTART;
                        end else begin
                            state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (cfg_abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (wrap) begin
                        period    <= shadow_period;
                        prescale  <= shadow_prescale;
                        upnotdown <= shadow_upnotdown;
                        en        <= shadow_en;
                        applied   <= 1'b1;
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
`ifdef PWM_CFG_TIMEOUT_EN
                    else if (wdog == TIMEOUT_CYCLES - 24'd1) begin
                        period      <= shadow_period;
                        prescale    <= shadow_prescale;
                        upnotdown   <= shadow_upnotdown;
                        en          <= shadow_en;
                        count_reset <= 1'b1;
                        timeout     <= 1'b1;
                        state       <= RESTART;
                    end else begin
                        wdog <= wdog + 24'd1;
                    end
`endif
                end
                RESTART: begin
                    count_reset <= 1'b0;
                    applied     <= 1'b1;
                    state       <= IDLE;
                    cfg_ready   <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    count_reset <= 1'b0;
                    state       <= IDLE;
                    cfg_ready   <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
